// File: rtl/sail_core_defs.sv
// Shared core definitions for the hazard-tracking scoreboard: register file
// geometry, countdown/outstanding-count widths and producer latency encodings.
package sail_core_defs;

    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    localparam int LAT_W      = 2;
    localparam int CNT_W      = 2;

    // Cycles a consumer must wait before the producer's result can be forwarded
    localparam logic [LAT_W-1:0] LAT_ALU  = 2'd0;
    localparam logic [LAT_W-1:0] LAT_LOAD = 2'd1;
    localparam logic [LAT_W-1:0] LAT_MUL  = 2'd3;

    // Largest value representable in a field of the given width
    function automatic int field_max(input int width);
        return (1 << width) - 1;
    endfunction

endpackage

// File: rtl/sb_entry.sv
// Scoreboard entry for a single architectural register: tracks how many writes
// to it are in flight and how many cycles remain until the youngest one can be
// forwarded to a consumer.
module sb_entry
    import sail_core_defs::*;
#(
    parameter int LW = LAT_W,
    parameter int CW = CNT_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          accept_i,
    input  logic [LW-1:0] lat_load_i,
    input  logic          wb_i,
    output logic [CW-1:0] cnt_o,
    output logic [LW-1:0] lat_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lat_q, lat_d;
    logic          retire;

    // Next-state: a WB only counts if something is outstanding; the youngest
    // accepted write reloads the countdown and an empty entry never counts down
    always_comb begin
        cnt_d  = cnt_q;
        lat_d  = lat_q;
        retire = wb_i && (cnt_q != '0);
        if (accept_i && !retire) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!accept_i && retire) begin
            cnt_d = cnt_q - CW'(1);
        end
        if (accept_i) begin
            lat_d = lat_load_i;
        end else if (lat_q != '0) begin
            lat_d = lat_q - LW'(1);
        end
        if (cnt_d == '0) begin
            lat_d = '0;
        end
    end

    // Entry state register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            lat_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            lat_q <= lat_d;
        end
    end

    assign cnt_o = cnt_q;
    assign lat_o = lat_q;

endmodule

// File: rtl/scoreboard_stall_unit.sv
// Producer-side hazard tracker. Records each register write leaving ID, stalls
// ID while a source operand cannot yet be forwarded or while a destination has
// no room for another outstanding write, and retires writes at WB.
// Optional feature macro: SCOREBOARD_PERF_EN adds the perf_stall_cycles counter.
module scoreboard_stall_unit
    import sail_core_defs::*;
#(
    parameter int NUM_REGS = sail_core_defs::NUM_REGS,
    parameter int LAT_W    = sail_core_defs::LAT_W,
    parameter int CNT_W    = sail_core_defs::CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic                  id_rs1_used,
    input  logic                  id_rs2_used,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_regwrite,
    input  logic [LAT_W-1:0]      id_latency,
    input  logic                  flush,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  stall,
    output logic                  rs1_pending,
    output logic                  rs2_pending,
    output logic                  busy
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0]    cnt_arr [NUM_REGS];
    logic [LAT_W-1:0]    lat_arr [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                hazard_1, hazard_2, waw_full, accept;

    // x0 is hardwired to zero and never has an outstanding write
    assign cnt_arr[0] = '0;
    assign lat_arr[0] = '0;

    generate
        for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
            sb_entry #(
                .LW (LAT_W),
                .CW (CNT_W)
            ) u_entry (
                .clk        (clk),
                .reset      (reset),
                .accept_i   (accept && (id_rd == REG_ADDR_W'(r))),
                .lat_load_i (id_latency),
                .wb_i       (wb_valid && (wb_rd == REG_ADDR_W'(r))),
                .cnt_o      (cnt_arr[r]),
                .lat_o      (lat_arr[r])
            );
        end
    endgenerate

    // A register is pending while any write to it is still in flight
    always_comb begin
        pending = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            pending[r] = (cnt_arr[r] != '0);
        end
    end

    // Stall when a used source is not forwardable yet or the destination's
    // outstanding-write counter would overflow; a squashed ID never stalls
    always_comb begin
        hazard_1 = id_rs1_used && (id_rs1 != '0) && pending[id_rs1] && (lat_arr[id_rs1] != '0);
        hazard_2 = id_rs2_used && (id_rs2 != '0) && pending[id_rs2] && (lat_arr[id_rs2] != '0);
        waw_full = id_regwrite && (id_rd != '0) && (cnt_arr[id_rd] == CNT_MAX);
        stall    = id_valid && !flush && (hazard_1 || hazard_2 || waw_full);
        accept   = id_valid && !flush && !stall && id_regwrite && (id_rd != '0);
    end

    assign rs1_pending = pending[id_rs1];
    assign rs2_pending = pending[id_rs2];
    assign busy        = |pending;

`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Free-running count of stalled cycles, wrapping naturally at 2**32
    always_comb begin
        perf_d = perf_q + 32'(stall);
    end

    // Perf counter register, cleared by synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cycles = perf_q;
`endif

endmodule
